seven_segment_scanner: RTL
==========================

// Module: seven_segment_scanner
// PURPOSE
//  Time-multiplexes one hex-to-7-segment decoder across NUM_DIGITS common-anode digits.
//  Holds a displayed value and a pending value with a valid/ready load handshake.
//  Scans digits with a blanking gap before each one, so no ghosting occurs.
//  Sits between the arithmetic result logic (the adder sum) and the board's segment/anode pins.
// PARAMETERS
//  NUM_DIGITS       4      digits scanned, >=2
//  TICKS_PER_DIGIT  50000  clk cycles per digit slot (blank + lit)
//  BLANK_TICKS      500    cycles per slot with all anodes off; 1 <= BLANK_TICKS < TICKS_PER_DIGIT
//  LZ_BLANK         1      1 = suppress leading zeros; digit 0 is never suppressed
// PORTS
//  clk         in   1             rising-edge clock
//  reset       in   1             synchronous, active-high
//  enable      in   1             1 = scan, 0 = dark/idle
//  value_in    in   4*NUM_DIGITS  nibble i drives digit i (digit 0 = LSD)
//  dp_in       in   NUM_DIGITS    decimal point per digit, 1 = on
//  load_valid  in   1             value_in/dp_in are valid
//  load_ready  out  1             pending slot is empty
//  frame_done  out  1             1-cycle pulse at end of the last digit slot
//  an_n        out  NUM_DIGITS    anode enables, active-low
//  segments_n  out  7             segment drive, active-low (decoder output)
//  dp_n        out  1             decimal point, active-low
// BEHAVIOUR
//  Reset (next edge): state=IDLE, idx=0, tick=0, shadow=0, pending empty, load_ready=1,
//    frame_done=0, an_n=all 1, segments_n=7'h7F, dp_n=1. Reset mid-scan gives the same result.
//  Handshake: accept when load_valid&&load_ready; value goes to pending; load_ready=0 from the next cycle.
//  Transfer pending->shadow happens only at a frame boundary, from the registered pending state:
//    - in SCAN: the cycle that frame_done is asserted;
//    - in IDLE: every cycle.
//    load_ready returns to 1 the cycle after the transfer.
//    If a value is accepted on a boundary cycle, it stays pending until the next boundary.
//  FSM: IDLE -> BLANK when enable=1; BLANK -> SHOW when tick==BLANK_TICKS-1;
//    SHOW -> BLANK when tick==TICKS_PER_DIGIT-1, with idx=idx+1 (wraps NUM_DIGITS-1 -> 0).
//    frame_done=1 on the SHOW exit of idx NUM_DIGITS-1.
//    enable=0 in any state -> IDLE next cycle; tick and idx clear to 0.
//  tick: $clog2(TICKS_PER_DIGIT) bits; counts 0..TICKS_PER_DIGIT-1 across BLANK+SHOW; clears on wrap.
//  Outputs are registered and lag the FSM state by 1 cycle.
//    BLANK or IDLE: an_n=all 1, segments_n=7'h7F, dp_n=1.
//    SHOW: an_n has bit idx low; segments_n=decode(shadow nibble idx); dp_n=~dp_shadow[idx].
//  Leading-zero suppression: with LZ_BLANK=1, digit i>0 whose nibbles i..NUM_DIGITS-1 are all 0
//    is dark for its whole slot (an_n bit stays 1). Its timing slot is still consumed.
//    dp_shadow[i]=1 overrides suppression for that digit.
//  Frame length = NUM_DIGITS*TICKS_PER_DIGIT cycles; frame_done period is constant while enabled.
// STRUCTURE
//  Shared package: state encoding {IDLE,BLANK,SHOW}, SEG_OFF=7'h7F, nibble width 4.
//  Sub-module: the team's existing hex->segment decoder SevenSegment (combinational, active-low),
//    one instance feeding the segments_n output register.
//  Counter/FSM, handshake, and LZ logic are inline.
// TESTING (NUM_DIGITS=4, TICKS_PER_DIGIT=8, BLANK_TICKS=2, LZ_BLANK=1)
//  Reset held 3 cycles -> an_n=4'hF, segments_n=7'h7F, dp_n=1, load_ready=1, frame_done=0.
//  Load 16'h12A4 while IDLE, then enable=1 -> an_n sequence 1110,1101,1011,0111;
//    each digit: 2 dark + 6 lit cycles; segments_n matches decoder for 4,A,2,1; frame_done every 32 cycles.
//  Load 16'h0005 -> only an_n[0] ever goes low; load 16'h0000 -> digit 0 shows 0;
//    add dp_in=4'b0100 -> digit 2 lit with blank segments and dp_n=0.
//  Two loads back-to-back mid-frame -> first accepted, load_ready=0 until cycle after frame_done;
//    displayed value changes only at a frame boundary.
//  load_valid asserted on the frame_done cycle with pending empty -> accepted;
//    value appears at the start of frame+2 (not the next frame).
//  enable dropped during digit 2 SHOW -> next cycle an_n=4'hF; re-enable restarts at digit 0 BLANK;
//    reset asserted mid-SHOW -> reset values on the next edge.

Source files
------------

// File: rtl/seven_segment_scanner_pkg.sv
// Shared definitions for the seven-segment scanner.
//   state_e  : scan FSM encoding (idle / blanking gap / digit lit)
//   NibbleW  : bits per displayed hex digit
//   SegW     : segment outputs per digit (a..g)
//   SegOff   : active-low "all segments off" pattern
package seven_segment_scanner_pkg;

    localparam int unsigned NibbleW = 4;
    localparam int unsigned SegW    = 7;

    localparam logic [SegW-1:0] SegOff = 7'h7F;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StShow  = 2'd2
    } state_e;

endpackage

// File: rtl/seven_segment_scanner_decoder.sv
// Hex-to-7-segment decoder (the SevenSegment block), purely combinational.
// Ports:
//   nibble_i     : hex digit 0..F
//   segments_n_o : active-low segments, bit order {g,f,e,d,c,b,a}
module seven_segment_scanner_decoder
    import seven_segment_scanner_pkg::*;
(
    input  logic [NibbleW-1:0] nibble_i,
    output logic [SegW-1:0]    segments_n_o
);

    logic [SegW-1:0] seg_on;

    // Table is written active-high (lit = 1) for readability, inverted at the output.
    always_comb begin
        seg_on = 7'h00;
        case (nibble_i)
            4'h0:    seg_on = 7'h3F;
            4'h1:    seg_on = 7'h06;
            4'h2:    seg_on = 7'h5B;
            4'h3:    seg_on = 7'h4F;
            4'h4:    seg_on = 7'h66;
            4'h5:    seg_on = 7'h6D;
            4'h6:    seg_on = 7'h7D;
            4'h7:    seg_on = 7'h07;
            4'h8:    seg_on = 7'h7F;
            4'h9:    seg_on = 7'h6F;
            4'hA:    seg_on = 7'h77;
            4'hB:    seg_on = 7'h7C;
            4'hC:    seg_on = 7'h39;
            4'hD:    seg_on = 7'h5E;
            4'hE:    seg_on = 7'h79;
            4'hF:    seg_on = 7'h71;
            default: seg_on = 7'h00;
        endcase
    end

    assign segments_n_o = ~seg_on;

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for NumDigits common-anode seven-segment digits.
// A pending value is loaded through a valid/ready handshake and copied into the
// displayed (shadow) value only at frame boundaries, so a frame never mixes values.
// Every digit slot starts with a dark gap of BlankTicks cycles to avoid ghosting.
// Ports:
//   clk_i          : rising-edge clock
//   reset_i        : synchronous, active-high reset
//   enable_i       : 1 = scan, 0 = dark/idle
//   value_in_i     : nibble i drives digit i (digit 0 = least significant)
//   dp_in_i        : decimal point per digit, 1 = on
//   load_valid_i   : value_in_i / dp_in_i are valid
//   load_ready_o   : pending slot is empty
//   frame_done_o   : one-cycle pulse at the end of the last digit slot
//   an_n_o         : anode enables, active-low
//   segments_n_o   : segment drive, active-low
//   dp_n_o         : decimal point, active-low
module seven_segment_scanner
    import seven_segment_scanner_pkg::*;
#(
    parameter int unsigned NumDigits     = 4,
    parameter int unsigned TicksPerDigit = 50000,
    parameter int unsigned BlankTicks    = 500,
    parameter bit          LzBlank       = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         enable_i,
    input  logic [NibbleW*NumDigits-1:0] value_in_i,
    input  logic [NumDigits-1:0]         dp_in_i,
    input  logic                         load_valid_i,
    output logic                         load_ready_o,
    output logic                         frame_done_o,
    output logic [NumDigits-1:0]         an_n_o,
    output logic [SegW-1:0]              segments_n_o,
    output logic                         dp_n_o
);

    localparam int unsigned IdxW  = $clog2(NumDigits);
    localparam int unsigned TickW = $clog2(TicksPerDigit);
    localparam int unsigned ValW  = NibbleW * NumDigits;

    localparam logic [IdxW-1:0]  LastIdx   = IdxW'(NumDigits - 1);
    localparam logic [TickW-1:0] BlankLast = TickW'(BlankTicks - 1);
    localparam logic [TickW-1:0] SlotLast  = TickW'(TicksPerDigit - 1);

    // ---------------------------------------------------------------------------------------
    // Scan FSM and counters
    // ---------------------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [TickW-1:0] tick_q,  tick_d;
    logic [IdxW-1:0]  idx_q,   idx_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            tick_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
        end
    end

    // tick runs across the whole slot (blank then lit) and only clears when the slot ends.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        if (!enable_i) begin
            state_d = StIdle;
            tick_d  = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StBlank;
                    tick_d  = '0;
                    idx_d   = '0;
                end
                StBlank: begin
                    tick_d = tick_q + 1'b1;
                    if (tick_q == BlankLast) begin
                        state_d = StShow;
                    end
                end
                StShow: begin
                    if (tick_q == SlotLast) begin
                        state_d = StBlank;
                        tick_d  = '0;
                        idx_d   = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    tick_d  = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------------------------
    // Load handshake: pending slot and displayed shadow
    // ---------------------------------------------------------------------------------------
    logic [ValW-1:0]      pend_q,      pend_d;
    logic [NumDigits-1:0] pend_dp_q,   pend_dp_d;
    logic                 pend_full_q, pend_full_d;
    logic [ValW-1:0]      shadow_q,    shadow_d;
    logic [NumDigits-1:0] dp_shadow_q, dp_shadow_d;
    logic                 frame_done_q, frame_done_d;
    logic                 accept;
    logic                 xfer;

    assign accept = load_valid_i && !pend_full_q;
    // Boundary uses the registered frame_done, so a value accepted on that same cycle
    // is not yet visible to the transfer and waits a full frame.
    assign xfer   = pend_full_q && (frame_done_q || (state_q == StIdle));

    always_comb begin
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        shadow_d    = shadow_q;
        dp_shadow_d = dp_shadow_q;
        if (accept) begin
            pend_d      = value_in_i;
            pend_dp_d   = dp_in_i;
            pend_full_d = 1'b1;
        end else if (xfer) begin
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            shadow_d    = pend_q;
            dp_shadow_d = pend_dp_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            shadow_q    <= '0;
            dp_shadow_q <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            shadow_q    <= shadow_d;
            dp_shadow_q <= dp_shadow_d;
        end
    end

    assign load_ready_o = !pend_full_q;

    // ---------------------------------------------------------------------------------------
    // Leading-zero detection and current-digit selection
    // ---------------------------------------------------------------------------------------
    logic [NumDigits-1:0] lz_mask;
    logic                 zero_run;

    // Walk from the most significant digit down; a digit is a leading zero while every
    // nibble at or above it is zero. Digit 0 always shows.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = int'(NumDigits) - 1; i >= 0; i--) begin
            zero_run   = zero_run && (shadow_q[i*NibbleW +: NibbleW] == '0);
            lz_mask[i] = LzBlank && zero_run && (i != 0);
        end
    end

    logic [NibbleW-1:0]   cur_nib;
    logic                 cur_dp;
    logic                 cur_lz;
    logic [NumDigits-1:0] cur_an_n;

    always_comb begin
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_lz   = 1'b0;
        cur_an_n = '1;
        for (int i = 0; i < int'(NumDigits); i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_nib     = shadow_q[i*NibbleW +: NibbleW];
                cur_dp      = dp_shadow_q[i];
                cur_lz      = lz_mask[i];
                cur_an_n[i] = 1'b0;
            end
        end
    end

    logic [SegW-1:0] dec_seg_n;

    seven_segment_scanner_decoder u_decoder (
        .nibble_i     (cur_nib),
        .segments_n_o (dec_seg_n)
    );

    // ---------------------------------------------------------------------------------------
    // Registered outputs (one cycle behind the FSM)
    // ---------------------------------------------------------------------------------------
    logic [NumDigits-1:0] an_n_q,  an_n_d;
    logic [SegW-1:0]      seg_n_q, seg_n_d;
    logic                 dp_n_q,  dp_n_d;

    // enable_i is folded in so the display goes dark on the very next cycle it drops.
    // A suppressed leading zero with its decimal point set lights only the point.
    always_comb begin
        an_n_d       = '1;
        seg_n_d      = SegOff;
        dp_n_d       = 1'b1;
        frame_done_d = enable_i && (state_q == StShow) && (tick_q == SlotLast) &&
                       (idx_q == LastIdx);
        if (enable_i && (state_q == StShow) && (!cur_lz || cur_dp)) begin
            an_n_d  = cur_an_n;
            dp_n_d  = !cur_dp;
            seg_n_d = cur_lz ? SegOff : dec_seg_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            an_n_q       <= '1;
            seg_n_q      <= SegOff;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an_n_o       = an_n_q;
    assign segments_n_o = seg_n_q;
    assign dp_n_o       = dp_n_q;
    assign frame_done_o = frame_done_q;

endmodule
